uart_rx_ext: RTL and testbench

Parametrised oversampling UART receiver and successor to the fixed 8N1 receiver. Adds configurable data width, optional parity, 1 or 2 stop bits, an input synchroniser, 3-sample majority voting and false-start rejection. Adds a valid/ready holding register with parity, framing and overrun error reporting. Sits between the pad-side serial line (sampled via the shared baud tick generator) and the byte-consuming logic (FIFO or command parser).

---
 rtl/uart_rx_ext.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with configurable frame format.
//
// Frame format: one start bit, then DATA_WIDTH data bits (LSB first), then an
// optional parity bit, then STOP_BITS stop bits. The serial line is first
// passed through a two-flop synchroniser. Each bit is then decided by a
// 3-sample majority vote taken around the middle of the bit period. A start
// bit that does not survive the vote is treated as a glitch and dropped.
// Each received word goes into a valid/ready holding register, which is
// flagged with parity and framing errors.
//
// Ports:
//   clk          system clock, rising edge
//   reset_in     synchronous active-low reset
//   s_tick       one-cycle oversample strobe, OVERSAMPLE per bit period
//   receiver_in  asynchronous serial input, idle high
//   rx_data      received word, stable while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer accepts rx_data when rx_valid && rx_ready
//   parity_err   parity mismatch for rx_data (qualified by rx_valid)
//   frame_err    a stop bit was sampled low for rx_data (qualified by rx_valid)
//   overrun_err  one-cycle pulse: frame completed into a full, unread register
//   busy         receiver FSM is not idle
module uart_rx_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  receiver_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam logic [S_W-1:0] S_LO  = S_W'(M - 1);
  localparam logic [S_W-1:0] S_MID = S_W'(M);
  localparam logic [S_W-1:0] S_HI  = S_W'(M + 1);
  localparam logic [S_W-1:0] S_END = S_W'(OVERSAMPLE - 1);
  localparam logic [3:0]     N_LAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t                state;
  logic [S_W-1:0]        s_cnt;
  logic [3:0]            n_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  smp0, smp1;
  logic                  par_bad, frame_bad;
  logic                  rx_p0, rx_p1;

  logic rxs;
  logic bit_val;
  logic last_stop;

  assign rxs       = rx_p1;
  // Third sample is the live synchronised value on the deciding tick.
  assign bit_val   = maj3(smp0, smp1, rxs);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      rx_p0       <= 1'b1;
      rx_p1       <= 1'b1;
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      smp0        <= 1'b0;
      smp1        <= 1'b0;
      par_bad     <= 1'b0;
      frame_bad   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // synchroniser stage boundary: receiver_in -> rx_p0 -> rx_p1 (rxs)
      rx_p0       <= receiver_in;
      rx_p1       <= rx_p0;
      overrun_err <= 1'b0;

      // Consumer read; a completion later in this block overrides the clear.
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state     <= START;
            s_cnt     <= '0;
            par_bad   <= 1'b0;
            frame_bad <= 1'b0;
          end
        end
        default: begin
          if (s_tick) begin
            if (s_cnt == S_LO)  smp0 <= rxs;
            if (s_cnt == S_MID) smp1 <= rxs;
            if (s_cnt == S_END) s_cnt <= '0;
            else                s_cnt <= s_cnt + 1'b1;

            case (state)
              START: begin
                if (s_cnt == S_HI && bit_val) begin
                  // start bit did not hold low: glitch, abandon
                  state <= IDLE;
                  s_cnt <= '0;
                end else if (s_cnt == S_END) begin
                  state <= DATA;
                  n_cnt <= '0;
                end
              end
              DATA: begin
                if (s_cnt == S_HI) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                if (s_cnt == S_END) begin
                  if (n_cnt == N_LAST) begin
                    state    <= (PARITY_EN != 0) ? PARITY : STOP;
                    stop_cnt <= 1'b0;
                  end else begin
                    n_cnt <= n_cnt + 4'd1;
                  end
                end
              end
              PARITY: begin
                if (s_cnt == S_HI) par_bad <= (bit_val != exp_parity(shreg));
                if (s_cnt == S_END) begin
                  state    <= STOP;
                  stop_cnt <= 1'b0;
                end
              end
              STOP: begin
                if (s_cnt == S_HI) begin
                  if (!bit_val) frame_bad <= 1'b1;
                  if (last_stop) begin
                    // Complete mid-bit so an early next start bit is caught.
                    state <= IDLE;
                    s_cnt <= '0;
                    if (!rx_valid || rx_ready) begin
                      rx_data    <= shreg;
                      parity_err <= par_bad;
                      frame_err  <= frame_bad | ~bit_val;
                      rx_valid   <= 1'b1;
                    end else begin
                      overrun_err <= 1'b1;
                    end
                  end
                end
                if (s_cnt == S_END) stop_cnt <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: dut_a is 8N1, dut_b is 8E2, both OVERSAMPLE=16.
module tb_uart_rx_ext;

  logic       clk;
  logic       reset_in;
  logic       s_tick;
  logic       line_a, line_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  uart_rx_ext #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick), .receiver_in(line_a),
    .rx_data(data_a), .rx_valid(vld_a), .rx_ready(ready_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_ext #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset_in(reset_in), .s_tick(s_tick), .receiver_in(line_b),
    .rx_data(data_b), .rx_valid(vld_b), .rx_ready(ready_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int tick_div = 0;
  int tick_total = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  int t0 = 0;
  int lat = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One s_tick pulse every 4 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      s_tick = (tick_div == 0);
      if (s_tick) tick_total++;
    end
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every accepted word is compared with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_a && ready_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_word actual=0x%0h required=none", data_a);
        end else begin
          e = q_a.pop_front();
          check("a_data", {24'd0, data_a}, {24'd0, e.d});
          check("a_parity_err", {31'd0, perr_a}, {31'd0, e.pe});
          check("a_frame_err", {31'd0, ferr_a}, {31'd0, e.fe});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_b && ready_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_word actual=0x%0h required=none", data_b);
        end else begin
          e = q_b.pop_front();
          check("b_data", {24'd0, data_b}, {24'd0, e.d});
          check("b_parity_err", {31'd0, perr_b}, {31'd0, e.pe});
          check("b_frame_err", {31'd0, ferr_b}, {31'd0, e.fe});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) line_a = v;
    else          line_b = v;
  endtask

  // Returns 1 time unit after the n-th clock edge that carries s_tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  // gbit >= 0 puts a one-tick low pulse at tick 8 of that data bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic with_par,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input int gbit);
    drive(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      if (i == gbit) begin
        wait_ticks(8);
        drive(sel, 1'b0);
        wait_ticks(1);
        drive(sel, d[i]);
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    if (with_par) begin
      drive(sel, pbit);
      wait_ticks(16);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(sel, stops[i]);
      wait_ticks(16);
    end
    drive(sel, 1'b1);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    return e;
  endfunction

  initial begin
    reset_in = 1'b0;
    line_a = 1'b1;
    line_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_data", {24'd0, data_a}, 32'd0);
    check("reset_a_valid", {31'd0, vld_a}, 32'd0);
    check("reset_a_busy", {31'd0, busy_a}, 32'd0);
    check("reset_a_errs", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    check("reset_b_data", {24'd0, data_b}, 32'd0);
    check("reset_b_valid", {31'd0, vld_b}, 32'd0);
    check("reset_b_busy", {31'd0, busy_b}, 32'd0);
    check("reset_b_errs", {29'd0, perr_b, ferr_b, ovr_b}, 32'd0);
    @(posedge clk); #1 reset_in = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5 with completion latency in ticks from the start edge
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, -1);
      begin
        t0 = tick_total;
        for (int i = 0; i < 3000 && !vld_a; i++) @(negedge clk);
        lat = tick_total - t0;
        checks++;
        if (!(vld_a && lat >= 152 && lat <= 155)) begin
          errors++;
          $display("FAIL a_latency actual=%0d ticks valid=%0d required=152..155 ticks", lat, vld_a);
        end
      end
    join
    wait_ticks(8);

    // glitch of 6 ticks: busy while low, back to idle with no output
    drive(0, 1'b0);
    wait_ticks(3);
    @(negedge clk);
    check("a_busy_during_start", {31'd0, busy_a}, 32'd1);
    wait_ticks(3);
    drive(0, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    check("a_idle_after_false_start", {31'd0, busy_a}, 32'd0);
    q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_ticks(8);

    // overrun: 0x11 held, 0x22 dropped
    ready_a = 1'b0;
    q_a.push_back(mk(8'h11, 1'b0, 1'b0));
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, -1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_ticks(8);
    @(negedge clk);
    check("a_valid_held", {31'd0, vld_a}, 32'd1);
    check("a_held_data", {24'd0, data_a}, 32'h11);
    check("a_overrun_pulses", ovr_cnt_a, 32'd1);
    @(posedge clk); #1 ready_a = 1'b1;
    @(posedge clk); #1 ready_a = 1'b0;
    @(negedge clk);
    check("a_valid_cleared", {31'd0, vld_a}, 32'd0);
    ready_a = 1'b1;
    wait_ticks(8);

    // reset in the middle of DATA, then a clean frame
    drive(0, 1'b0);
    wait_ticks(16 + 16 * 3);
    @(negedge clk);
    check("a_busy_mid_data", {31'd0, busy_a}, 32'd1);
    @(posedge clk); #1 reset_in = 1'b0; drive(0, 1'b1);
    @(posedge clk); #1 reset_in = 1'b1;
    @(negedge clk);
    check("a_busy_after_reset", {31'd0, busy_a}, 32'd0);
    check("a_valid_after_reset", {31'd0, vld_a}, 32'd0);
    wait_ticks(20);
    check("a_still_idle", {31'd0, busy_a}, 32'd0);
    q_a.push_back(mk(8'hF0, 1'b0, 1'b0));
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1, 2'b11, -1);
    wait_ticks(8);

    // 8E2: 0x03 has even weight, so the correct parity bit is 0
    q_b.push_back(mk(8'h03, 1'b1, 1'b0));
    send_frame(1, 8'h03, 1'b1, 1'b1, 2, 2'b11, -1);
    wait_ticks(4);
    q_b.push_back(mk(8'h03, 1'b0, 1'b0));
    send_frame(1, 8'h03, 1'b1, 1'b0, 2, 2'b11, -1);
    wait_ticks(4);
    // second stop bit low; the tail of that low is a rejected false start
    q_b.push_back(mk(8'h55, 1'b0, 1'b1));
    send_frame(1, 8'h55, 1'b1, 1'b0, 2, 2'b01, -1);
    wait_ticks(30);
    @(negedge clk);
    check("b_idle_after_stop_low", {31'd0, busy_b}, 32'd0);
    // one-tick low pulse inside data bit 0 is outvoted
    q_b.push_back(mk(8'hFF, 1'b0, 1'b0));
    send_frame(1, 8'hFF, 1'b1, 1'b0, 2, 2'b11, 0);
    wait_ticks(40);

    @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    check("a_overrun_total", ovr_cnt_a, 32'd1);
    check("b_overrun_total", ovr_cnt_b, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
